// File: rtl/test_mem_initiator.sv
// test_mem_initiator: turns single-cycle read/write start pulses from the test
// CSR into one OBI transaction (or a write-then-read-back pair) and reports
// busy/done/error status plus the last read data.
module test_mem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_read_i,
  input  logic        start_write_i,
  input  logic [31:0] address_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic [31:0] addr_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i
);

  // A zero timeout disables the check; keep the counter at least one bit wide.
  localparam bit              TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int unsigned     CW      = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]   TO_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {IDLE, W_REQ, W_RSP, R_REQ, R_RSP} state_e;

  state_e        state;
  logic          verify;   // read-back pending after the write phase
  logic [CW-1:0] cnt;
  logic          timeout;

  // Last cycle of the wait budget for the current phase.
  assign timeout = TO_EN && (cnt == TO_LAST);
  assign busy_o  = (state != IDLE);
  assign be_o    = 4'hF;

  // Sequencer: acceptance, request/response phases, timeout and status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      verify  <= 1'b0;
      cnt     <= '0;
      rdata_o <= '0;
      done_o  <= 1'b0;
      error_o <= 1'b0;
      req_o   <= 1'b0;
      addr_o  <= '0;
      we_o    <= 1'b0;
      wdata_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (state != IDLE) cnt <= cnt + 1'b1;
      unique case (state)
        IDLE: begin
          // The done cycle is still treated as busy for incoming starts.
          if (!done_o && (start_read_i || start_write_i)) begin
            addr_o  <= address_i;
            wdata_o <= wdata_i;
            error_o <= 1'b0;
            req_o   <= 1'b1;
            cnt     <= '0;
            verify  <= start_read_i && start_write_i;
            if (start_write_i) begin
              state <= W_REQ;
              we_o  <= 1'b1;
            end else begin
              state <= R_REQ;
              we_o  <= 1'b0;
            end
          end
        end
        W_REQ, R_REQ: begin
          if (gnt_i) begin
            req_o <= 1'b0;
            cnt   <= '0;
            state <= (state == W_REQ) ? W_RSP : R_RSP;
          end else if (timeout) begin
            req_o   <= 1'b0;
            error_o <= 1'b1;
            done_o  <= 1'b1;
            verify  <= 1'b0;
            state   <= IDLE;
          end
        end
        W_RSP: begin
          if (rvalid_i) begin
            if (err_i) begin
              error_o <= 1'b1;
              done_o  <= 1'b1;
              verify  <= 1'b0;
              state   <= IDLE;
            end else if (verify) begin
              // Read back the word just written, same address.
              req_o  <= 1'b1;
              we_o   <= 1'b0;
              cnt    <= '0;
              verify <= 1'b0;
              state  <= R_REQ;
            end else begin
              done_o <= 1'b1;
              state  <= IDLE;
            end
          end else if (timeout) begin
            error_o <= 1'b1;
            done_o  <= 1'b1;
            verify  <= 1'b0;
            state   <= IDLE;
          end
        end
        R_RSP: begin
          if (rvalid_i) begin
            if (err_i) error_o <= 1'b1;
            else       rdata_o <= rdata_i;
            done_o <= 1'b1;
            state  <= IDLE;
          end else if (timeout) begin
            error_o <= 1'b1;
            done_o  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_mem_initiator.sv
// Bench for test_mem_initiator: table of transactions plus hand sequences for
// timeout, busy-drop/stray response and reset mid-operation. A bus responder
// grants/responds with configurable waits; a scoreboard checks each request
// on the bus and each completion on done_o.
module tb_test_mem_initiator;
  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_read_i = 1'b0, start_write_i = 1'b0;
  logic [31:0] address_i = '0, wdata_i = '0;
  logic [31:0] rdata_o;
  logic        busy_o, done_o, error_o;
  logic        req_o, gnt_i = 1'b0;
  logic [31:0] addr_o, wdata_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic        rvalid_i = 1'b0, err_i = 1'b0;
  logic [31:0] rdata_i = '0;

  always #5 clk_i = ~clk_i;

  test_mem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .start_read_i(start_read_i), .start_write_i(start_write_i),
    .address_i(address_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
    .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i)
  );

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  typedef struct packed { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;
  typedef struct {
    logic rd, wr; logic [31:0] addr, wdata; int gw, rw;
    logic [31:0] rdata; logic werr, rerr; logic [31:0] exp_rdata; logic exp_err;
  } vec_t;

  exp_t exp_q[$];
  req_t req_q[$];

  int checks = 0, fails = 0;

  // Responder configuration
  int          gnt_wait = 0, rv_wait = 0;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_werr = 1'b0, cfg_rerr = 1'b0, stray = 1'b0;
  // Responder state
  int   g_cnt = 0, rv_cnt = 0;
  logic pend_rsp = 1'b0, pend_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder and scoreboard, acting just after each rising edge.
  always begin
    exp_t e;
    req_t r;
    @(posedge clk_i); #1;
    gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = '0;
    if (done_o) begin
      if (exp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_done: done_o=1 with no operation outstanding");
      end else begin
        e = exp_q.pop_front();
        chk("done_rdata", rdata_o, e.rdata);
        chk("done_error", {31'b0, error_o}, {31'b0, e.err});
        chk("done_busy", {31'b0, busy_o}, 32'd0);
      end
    end
    if (pend_rsp) begin
      if (rv_cnt == rv_wait) begin
        rvalid_i = 1'b1;
        err_i    = pend_we ? cfg_werr : cfg_rerr;
        rdata_i  = pend_we ? 32'hBAD0_BAD0 : cfg_rdata;
        pend_rsp = 1'b0;
      end else rv_cnt++;
    end else if (stray) begin
      rvalid_i = 1'b1; err_i = 1'b1; rdata_i = 32'hDEAD_0000;
    end
    if (req_o && !pend_rsp && !rvalid_i) begin
      if (req_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_req: req_o=1 addr %h with no request expected", addr_o);
      end else begin
        r = req_q[0];
        chk("req_addr", addr_o, r.addr);
        chk("req_we", {31'b0, we_o}, {31'b0, r.we});
        chk("req_be", {28'b0, be_o}, 32'hF);
        if (r.we) chk("req_wdata", wdata_o, r.wdata);
        if (g_cnt == gnt_wait) begin
          gnt_i = 1'b1; pend_rsp = 1'b1; pend_we = we_o; rv_cnt = 0; g_cnt = 0;
          void'(req_q.pop_front());
        end else g_cnt++;
      end
    end else if (!req_o) g_cnt = 0;
  end

  task automatic start(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    start_read_i = rd; start_write_i = wr; address_i = a; wdata_i = d;
    @(posedge clk_i); #1;
    start_read_i = 1'b0; start_write_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n = 0;
    while (!done_o && n < maxc) begin @(posedge clk_i); #1; n++; end
    checks++;
    if (!done_o) begin
      fails++;
      $display("FAIL %s_done_wait: done_o=0 after %0d cycles, expected 1", name, n);
    end
  endtask

  task automatic push_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic werr,
                         input logic [31:0] er, input logic ee);
    exp_q.push_back('{rdata: er, err: ee});
    if (wr) req_q.push_back('{addr: a, we: 1'b1, wdata: d});
    if (rd && !(wr && werr)) req_q.push_back('{addr: a, we: 1'b0, wdata: d});
  endtask

  vec_t vec[6];

  initial begin
    int reqc;
    vec[0] = '{1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[1] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0, 3, 2, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0};
    vec[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 0, 0, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'hA5A5_A5A5, 1'b0};
    vec[3] = '{1'b1, 1'b1, 32'h0000_0080, 32'h1111_2222, 0, 0, 32'h3333_4444, 1'b1, 1'b0, 32'hA5A5_A5A5, 1'b1};
    vec[4] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 0, 1, 32'hFFFF_0000, 1'b0, 1'b1, 32'hA5A5_A5A5, 1'b1};
    vec[5] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0, 7, 7, 32'h0BAD_CAFE, 1'b0, 1'b0, 32'h0BAD_CAFE, 1'b0};

    // Reset values
    #2;
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_flags", {26'b0, busy_o, done_o, error_o, req_o, we_o, 1'b0}, 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_be", {28'b0, be_o}, 32'hF);
    @(posedge clk_i); @(posedge clk_i); #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Table-driven transactions
    for (int i = 0; i < 6; i++) begin
      gnt_wait = vec[i].gw; rv_wait = vec[i].rw; cfg_rdata = vec[i].rdata;
      cfg_werr = vec[i].werr; cfg_rerr = vec[i].rerr;
      push_op(vec[i].rd, vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].werr,
              vec[i].exp_rdata, vec[i].exp_err);
      start(vec[i].rd, vec[i].wr, vec[i].addr, vec[i].wdata);
      chk("accept_state", {29'b0, busy_o, req_o, error_o}, 32'b110);
      wait_done($sformatf("vec%0d", i), 40);
      @(posedge clk_i); #1;
    end

    // Timeout: grant never arrives
    gnt_wait = 1000; cfg_werr = 1'b0; cfg_rerr = 1'b0;
    push_op(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0BAD_CAFE, 1'b1);
    start(1'b1, 1'b0, 32'h100, 32'h0);
    reqc = 0;
    for (int n = 0; n < 30 && !done_o; n++) begin
      if (req_o) reqc++;
      @(posedge clk_i); #1;
    end
    chk("timeout_req_cycles", reqc, TO);
    chk("timeout_done", {31'b0, done_o}, 32'd1);
    req_q.delete();
    @(posedge clk_i); #1;
    gnt_wait = 0; rv_wait = 0; cfg_rdata = 32'h600D_F00D;
    push_op(1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 32'h600D_F00D, 1'b0);
    start(1'b1, 1'b0, 32'h104, 32'h0);
    chk("timeout_err_clear", {31'b0, error_o}, 32'd0);
    wait_done("after_timeout", 20);
    @(posedge clk_i); #1;

    // Busy drop, start in done cycle, stray response while idle
    gnt_wait = 2; rv_wait = 1;
    push_op(1'b0, 1'b1, 32'h200, 32'h11, 1'b0, 32'h600D_F00D, 1'b0);
    start(1'b0, 1'b1, 32'h200, 32'h11);
    start(1'b1, 1'b1, 32'h300, 32'h22);
    wait_done("busy_drop", 20);
    start(1'b0, 1'b1, 32'h400, 32'h33);
    chk("done_cycle_start", {30'b0, busy_o, req_o}, 32'd0);
    stray = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    stray = 1'b0;
    @(posedge clk_i); #1;
    chk("stray_state", {30'b0, busy_o, error_o}, 32'd0);
    chk("stray_rdata", rdata_o, 32'h600D_F00D);

    // Reset during R_RSP; the late response must be ignored
    gnt_wait = 0; rv_wait = 5; cfg_rdata = 32'h7777_7777;
    push_op(1'b1, 1'b0, 32'h500, 32'h99, 1'b0, 32'h0, 1'b0);
    start(1'b1, 1'b0, 32'h500, 32'h99);
    @(posedge clk_i); #1;
    chk("pre_rst_busy", {31'b0, busy_o}, 32'd1);
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    exp_q.delete(); req_q.delete();
    #1;
    chk("midrst_rdata", rdata_o, 32'h0);
    chk("midrst_flags", {26'b0, busy_o, done_o, error_o, req_o, we_o, 1'b0}, 32'h0);
    chk("midrst_addr", addr_o, 32'h0);
    chk("midrst_wdata", wdata_o, 32'h0);
    chk("midrst_be", {28'b0, be_o}, 32'hF);
    @(posedge clk_i); #3 rst_ni = 1'b1;
    repeat (8) @(posedge clk_i);
    #1;
    chk("late_rvalid_rdata", rdata_o, 32'h0);
    chk("late_rvalid_state", {30'b0, busy_o, error_o}, 32'd0);
    chk("late_rvalid_drained", {31'b0, pend_rsp}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
    $fatal(1);
  end

endmodule
